demux14_stream: RTL and testbench
=================================

Name: demux14_stream

Overview:
Registered 1-to-4 stream demultiplexer. It steers a single valid/ready input stream to one of four output channels, selected either by an explicit 2-bit select or by an internal round-robin pointer. It is the distribution end paired with the 4:1 selection datapath: the mux merges four sources onto one line, and this block fans one line back out to four sinks. Each output channel has its own one-entry holding register, so sinks can apply backpressure independently.

Parameters:
DATA_W, 8, width of the data path on the input and on every output channel.
CNT_W, 8, width of the accepted-beat counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  input beat present.
in_ready  output  1  block can accept the input beat this cycle.
in_data  input  DATA_W  input payload.
in_sel  input  2  target channel when auto_en=0.
auto_en  input  1  1 selects round-robin steering; in_sel is then ignored.
out_valid  output  4  per-channel valid; bit i belongs to channel i.
out_ready  input  4  per-channel sink ready.
out_data0  output  DATA_W  channel 0 payload.
out_data1  output  DATA_W  channel 1 payload.
out_data2  output  DATA_W  channel 2 payload.
out_data3  output  DATA_W  channel 3 payload.
rr_ptr  output  2  current round-robin pointer.
beat_cnt  output  CNT_W  count of accepted input beats.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=4'b0000, out_data0..3=0, rr_ptr=0, beat_cnt=0.
  - Any held data is discarded, including reset asserted mid-stream.
- Target channel: t = auto_en ? rr_ptr : in_sel.
- Channel i is free when out_valid[i]=0 or out_ready[i]=1.
- Input handshake:
  - in_ready = free[t], combinational from out_ready, in_sel, auto_en and rr_ptr.
  - Accept = in_valid & in_ready.
  - Upstream holds in_data, in_sel and auto_en stable while in_valid=1 and in_ready=0.
- On accept, at the next edge:
  - out_data<t> <= in_data and out_valid[t] <= 1.
  - Latency: exactly 1 cycle from accept to out_valid.
- Drain: out_valid[i] clears when out_valid[i] & out_ready[i] and channel i is not loaded in the same cycle.
- Simultaneous drain and load on the same channel: the new data replaces the old and out_valid[i] stays 1. This gives full throughput of 1 beat/cycle per channel.
- Non-target channels hold their data and valid unchanged. A channel's out_data is stable while its out_valid=1 and out_ready=0.
- Round-robin pointer:
  - Advances only on accept with auto_en=1, as rr_ptr+1 mod 4, so 3 wraps to 0.
  - Holds when auto_en=0 or when there is no accept.
  - Toggling auto_en does not reset rr_ptr.
- beat_cnt:
  - Increments by 1 on every accept in either mode.
  - Wraps from 2^CNT_W-1 to 0; no saturation.
- Blocking: a blocked target stalls the input even if other channels are free. There is no reordering and no skip-ahead in round-robin mode.
- No combinational path from in_valid to out_valid. All outputs except in_ready are registered.

Test Plan:
1. Reset then select sweep: auto_en=0, out_ready=4'hF, send in_data=8'hA1,B2,C3,D4 with in_sel=0,1,2,3 on consecutive cycles -> each channel shows its byte 1 cycle after accept; beat_cnt=4; rr_ptr=0.
2. Round-robin: auto_en=1, out_ready=4'hF, send 6 beats 8'h10..8'h15 -> channels 0,1,2,3,0,1 receive them; rr_ptr ends at 2; beat_cnt=6.
3. Backpressure: out_ready[2]=0, in_sel=2, send 8'h55 then 8'h66 -> 8'h55 is held on out_data2; in_ready=0 for the second beat until out_ready[2]=1; then 8'h66 is loaded in the same cycle 8'h55 drains, with out_valid[2] staying 1.
4. Isolation: channel 1 held (out_valid[1]=1, out_ready[1]=0, data 8'h77) while beats go to channels 0 and 3 -> out_data1 stays 8'h77; channels 0/3 deliver normally.
5. Counter wrap: CNT_W=8, 257 accepts -> beat_cnt=1.
6. Reset mid-operation: rst_n low for 1 ns while out_valid=4'b1011 -> out_valid=0, data=0, rr_ptr=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/demux14_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer with explicit or round-robin steering.
// Each output channel owns a one-entry holding register, so sinks back-pressure independently.
module demux14_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_sel,
    input  logic              auto_en,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    output logic [1:0]        rr_ptr,
    output logic [CNT_W-1:0]  beat_cnt
);

    logic [1:0]        w_tgt;
    logic [3:0]        w_free;
    logic              w_accept;
    logic [3:0]        w_load;

    logic [3:0]        r_valid;
    logic [DATA_W-1:0] r_data [4];
    logic [1:0]        r_rr;
    logic [CNT_W-1:0]  r_cnt;

    // A blocked target stalls the input even when other channels are free.
    always_comb begin
        w_tgt         = auto_en ? r_rr : in_sel;
        w_free        = ~r_valid | out_ready;
        in_ready      = w_free[w_tgt];
        w_accept      = in_valid & in_ready;
        w_load        = '0;
        w_load[w_tgt] = w_accept;
    end

    for (genvar g = 0; g < 4; g++) begin : g_chan
        // Load wins over drain, so a simultaneous drain+load keeps valid high.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid[g] <= 1'b0;
                r_data[g]  <= '0;
            end else if (w_load[g]) begin
                r_valid[g] <= 1'b1;
                r_data[g]  <= in_data;
            end else if (out_ready[g]) begin
                r_valid[g] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr  <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            if (auto_en) begin
                r_rr <= r_rr + 2'd1;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data0 = r_data[0];
    assign out_data1 = r_data[1];
    assign out_data2 = r_data[2];
    assign out_data3 = r_data[3];
    assign rr_ptr    = r_rr;
    assign beat_cnt  = r_cnt;

endmodule

// File: tb/tb_demux14_stream.sv
// Self-checking bench for demux14_stream: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural channel model.
module tb_demux14_stream;

    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [1:0]    in_sel = '0;
    logic          auto_en = 1'b0;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready = '0;
    logic [DW-1:0] out_data0, out_data1, out_data2, out_data3;
    logic [1:0]    rr_ptr;
    logic [CW-1:0] beat_cnt;

    demux14_stream #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .auto_en(auto_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1),
        .out_data2(out_data2), .out_data3(out_data3),
        .rr_ptr(rr_ptr), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: per-channel occupancy and contents, pointer and count as integers.
    bit [3:0] m_valid;
    int       m_data [4];
    int       m_rr;
    int       m_cnt;
    bit       m_last_acc;

    function automatic int m_target();
        return auto_en ? m_rr : int'(in_sel);
    endfunction

    function automatic bit m_ready();
        int t = m_target();
        return (m_valid[t] == 1'b0) || (out_ready[t] == 1'b1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid    = '0;
            for (int i = 0; i < 4; i++) m_data[i] = 0;
            m_rr       = 0;
            m_cnt      = 0;
            m_last_acc = 1'b0;
        end else begin
            bit acc;
            int t;
            t   = m_target();
            acc = in_valid && m_ready();
            for (int i = 0; i < 4; i++) begin
                if (acc && t == i) begin
                    m_valid[i] = 1'b1;
                    m_data[i]  = int'(in_data);
                end else if (out_ready[i]) begin
                    m_valid[i] = 1'b0;
                end
            end
            if (acc) begin
                m_cnt = (m_cnt + 1) % (1 << CW);
                if (auto_en) m_rr = (m_rr + 1) % 4;
            end
            m_last_acc = acc;
        end
    end

    // Compare process: outputs are stable 1 time unit after the falling edge.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            chk("m_out_valid", 32'(out_valid), 32'(m_valid));
            chk("m_out_data0", 32'(out_data0), 32'(m_data[0]));
            chk("m_out_data1", 32'(out_data1), 32'(m_data[1]));
            chk("m_out_data2", 32'(out_data2), 32'(m_data[2]));
            chk("m_out_data3", 32'(out_data3), 32'(m_data[3]));
            chk("m_rr_ptr",    32'(rr_ptr),    32'(m_rr));
            chk("m_beat_cnt",  32'(beat_cnt),  32'(m_cnt));
            chk("m_in_ready",  32'(in_ready),  32'(m_ready()));
        end
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] s,
                         input logic a, input logic [3:0] r);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        auto_en   = a;
        out_ready = r;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        #1;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data0", 32'(out_data0), 32'h0);
        chk("rst_rr",    32'(rr_ptr),    32'h0);
        chk("rst_cnt",   32'(beat_cnt),  32'h0);

        // Select sweep
        drive(1, 8'hA1, 2'd0, 0, 4'hF);
        drive(1, 8'hB2, 2'd1, 0, 4'hF);
        chk("t1_valid_lat", 32'(out_valid), 32'h1);
        chk("t1_data0",     32'(out_data0), 32'hA1);
        drive(1, 8'hC3, 2'd2, 0, 4'hF);
        drive(1, 8'hD4, 2'd3, 0, 4'hF);
        drive(0, 8'h00, 2'd0, 0, 4'hF);
        chk("t1_valid_end", 32'(out_valid), 32'h8);
        chk("t1_data1",     32'(out_data1), 32'hB2);
        chk("t1_data2",     32'(out_data2), 32'hC3);
        chk("t1_data3",     32'(out_data3), 32'hD4);
        chk("t1_cnt",       32'(beat_cnt),  32'd4);
        chk("t1_rr",        32'(rr_ptr),    32'd0);

        // Round-robin
        for (int k = 0; k < 6; k++) drive(1, 8'(8'h10 + k), 2'd3, 1, 4'hF);
        drive(0, 8'h00, 2'd0, 1, 4'hF);
        chk("t2_rr",    32'(rr_ptr),    32'd2);
        chk("t2_cnt",   32'(beat_cnt),  32'd10);
        chk("t2_data0", 32'(out_data0), 32'h14);
        chk("t2_data1", 32'(out_data1), 32'h15);
        chk("t2_data2", 32'(out_data2), 32'h12);
        chk("t2_data3", 32'(out_data3), 32'h13);
        chk("t2_valid", 32'(out_valid), 32'h2);

        // Backpressure on channel 2
        drive(1, 8'h55, 2'd2, 0, 4'b1011);
        drive(1, 8'h66, 2'd2, 0, 4'b1011);
        chk("t3_blocked",  32'(in_ready),  32'd0);
        chk("t3_held",     32'(out_data2), 32'h55);
        drive(1, 8'h66, 2'd2, 0, 4'b1011);
        chk("t3_blocked2", 32'(in_ready),  32'd0);
        drive(1, 8'h66, 2'd2, 0, 4'hF);
        chk("t3_release",  32'(in_ready),  32'd1);
        drive(0, 8'h00, 2'd0, 0, 4'hF);
        chk("t3_valid",    32'(out_valid), 32'h4);
        chk("t3_data2",    32'(out_data2), 32'h66);
        chk("t3_cnt",      32'(beat_cnt),  32'd12);

        // Isolation of a held channel 1
        drive(1, 8'h77, 2'd1, 0, 4'b1101);
        drive(1, 8'h01, 2'd0, 0, 4'b1101);
        chk("t4_held1", 32'(out_data1), 32'h77);
        drive(1, 8'h03, 2'd3, 0, 4'b1101);
        drive(0, 8'h00, 2'd0, 0, 4'b1101);
        chk("t4_valid", 32'(out_valid), 32'hA);
        chk("t4_data1", 32'(out_data1), 32'h77);
        chk("t4_data0", 32'(out_data0), 32'h01);
        chk("t4_data3", 32'(out_data3), 32'h03);
        drive(0, 8'h00, 2'd0, 0, 4'hF);
        chk("t4_cnt",   32'(beat_cnt),  32'd15);

        // Counter wrap
        do_reset();
        for (int k = 0; k < 257; k++) drive(1, 8'(k), 2'd0, 1, 4'hF);
        drive(0, 8'h00, 2'd0, 1, 4'hF);
        chk("t5_cnt_wrap", 32'(beat_cnt), 32'd1);
        chk("t5_rr",       32'(rr_ptr),   32'd1);

        // Asynchronous reset with channels 0,1,3 occupied
        do_reset();
        drive(1, 8'h81, 2'd0, 1, 4'h0);
        drive(1, 8'h82, 2'd0, 1, 4'h0);
        drive(1, 8'h83, 2'd3, 0, 4'h0);
        drive(0, 8'h00, 2'd0, 0, 4'h0);
        chk("t6_pre_valid", 32'(out_valid), 32'hB);
        chk("t6_pre_rr",    32'(rr_ptr),    32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 32'h0);
        chk("t6_data0", 32'(out_data0), 32'h0);
        chk("t6_data3", 32'(out_data3), 32'h0);
        chk("t6_rr",    32'(rr_ptr),    32'd0);
        chk("t6_cnt",   32'(beat_cnt),  32'd0);
        rst_n = 1'b1;

        // Randomized traffic; a stalled beat keeps its payload and steering stable
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!(in_valid && !m_last_acc)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 8'($urandom);
                in_sel   = 2'($urandom_range(0, 3));
                auto_en  = ($urandom_range(0, 2) == 0);
            end
            out_ready = 4'($urandom) | 4'($urandom);
        end
        drive(0, 8'h00, 2'd0, 0, 4'hF);
        drive(0, 8'h00, 2'd0, 0, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
